// File: rtl/qsfp_i2c_pkg.sv
// qsfp_i2c_pkg: register map, reset-release step data and sequencer state
// encoding shared by the QSFP I2C reset sequencer.
package qsfp_i2c_pkg;

  localparam logic [31:0] ADDR_CONTROL    = 32'h0000_0014;
  localparam logic [31:0] ADDR_STATUS_TOP = 32'h0000_0020;
  localparam logic [31:0] ADDR_STATUS_P0  = 32'h0000_0028;
  localparam logic [31:0] ADDR_STATUS_P1  = 32'h0000_002C;
  localparam logic [31:0] ADDR_STATUS_P2  = 32'h0000_0030;
  localparam logic [31:0] ADDR_STATUS_P3  = 32'h0000_0034;

  // CONTROL reset-release bit positions
  localparam int unsigned CTRL_BIT_TOP   = 0;
  localparam int unsigned CTRL_BIT_I2C   = 1;
  localparam int unsigned CTRL_BIT_MUX0  = 2;
  localparam int unsigned CTRL_BIT_MUX1  = 3;
  localparam int unsigned CTRL_BIT_QSFP0 = 4;

  localparam logic [2:0] LAST_STEP = 3'd4;

  // Cumulative CONTROL value written at each step; entry 0 is step 0.
  localparam logic [4:0][7:0] STEP_WDATA = {8'hFF, 8'h0F, 8'h07, 8'h03, 8'h01};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_GAP,
`ifdef QSFP_RSTSEQ_INSERT_GATE_EN
    S_RD_INS,
`endif
    S_POLL_SETUP,
    S_POLL,
    S_ABORT_WR
  } seq_state_e;

  // Address of STATUS_Pn; the per-port status registers are word-spaced.
  function automatic logic [31:0] status_port_addr(input logic [1:0] idx);
    return ADDR_STATUS_P0 + {28'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/qsfp_rstseq_timer.sv
// qsfp_rstseq_timer: loadable down-counter that saturates at zero.
// zero_o is high in the cycle the count reaches zero (count is 1) or once it
// already sits at zero, so a waiting FSM can leave on that same cycle.
module qsfp_rstseq_timer #(
  parameter int unsigned MAX = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);
  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: load has priority, decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(MAX);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q <= W'(1));

endmodule

// File: rtl/qsfp_i2c_rstseq.sv
// qsfp_i2c_rstseq: releases the QSFP I2C CONTROL resets in a fixed order,
// then polls STATUS_TOP for the ready state or times out.
// Optional macro QSFP_RSTSEQ_INSERT_GATE_EN: read STATUS_P0..P3 before the
// last step and release only the ports whose inserted bit (bit 8) is set.
//
// state        | meaning
// IDLE         | waiting for start
// WR           | CONTROL write strobe on the bus
// GAP          | idle gap after a write
// RD_INS       | (macro only) reading per-port insertion bits
// POLL_SETUP   | point m_addr at STATUS_TOP, arm timeout
// POLL         | compare STATUS_TOP with the ready value
// ABORT_WR     | write 0 to CONTROL, re-asserting every reset
module qsfp_i2c_rstseq
  import qsfp_i2c_pkg::*;
#(
  parameter int unsigned STEP_DLY        = 1000,
  parameter int unsigned POLL_TIMEOUT    = 100000,
  parameter logic [7:0]  TOP_READY_STATE = 8'h02
) (
  input  logic        sys_if_clk,
  input  logic        sys_if_rstn,
  input  logic        start,
  input  logic        abort,
  output logic        seq_busy,
  output logic        seq_done,
  output logic        seq_error,
  output logic [2:0]  seq_step,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);
  seq_state_e  state_q;
  logic        busy_q, done_q, error_q, wen_q;
  logic [2:0]  step_q;
  logic [31:0] addr_q, wdata_q;
  logic        gap_load, gap_en, gap_zero;
  logic        poll_load, poll_en, poll_zero;
  logic        ready;
  logic        unused_rdata;
`ifdef QSFP_RSTSEQ_INSERT_GATE_EN
  logic [3:0]  ins_q;
  logic [1:0]  ins_idx_q;
  logic        ins_ph_q;
`endif

  assign gap_load  = (state_q == S_WR);
  assign gap_en    = (state_q == S_GAP);
  assign poll_load = (state_q == S_POLL_SETUP);
  assign poll_en   = (state_q == S_POLL);
  assign ready     = (m_rdata[7:0] == TOP_READY_STATE);
  assign unused_rdata = ^m_rdata[31:8];

  qsfp_rstseq_timer #(.MAX(STEP_DLY)) u_gap_timer (
    .clk_i (sys_if_clk),
    .rst_ni(sys_if_rstn),
    .load_i(gap_load),
    .en_i  (gap_en),
    .zero_o(gap_zero)
  );

  qsfp_rstseq_timer #(.MAX(POLL_TIMEOUT)) u_poll_timer (
    .clk_i (sys_if_clk),
    .rst_ni(sys_if_rstn),
    .load_i(poll_load),
    .en_i  (poll_en),
    .zero_o(poll_zero)
  );

  // sequencer FSM with registered bus and status outputs
  always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
    if (!sys_if_rstn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      wen_q   <= 1'b0;
      step_q  <= 3'd0;
      addr_q  <= ADDR_CONTROL;
      wdata_q <= 32'd0;
`ifdef QSFP_RSTSEQ_INSERT_GATE_EN
      ins_q     <= 4'd0;
      ins_idx_q <= 2'd0;
      ins_ph_q  <= 1'b0;
`endif
    end else begin
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q <= S_ABORT_WR;
        addr_q  <= ADDR_CONTROL;
        wdata_q <= 32'd0;
        wen_q   <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_WR;
              busy_q  <= 1'b1;
              error_q <= 1'b0;
              step_q  <= 3'd0;
              addr_q  <= ADDR_CONTROL;
              wdata_q <= {24'd0, STEP_WDATA[0]};
              wen_q   <= 1'b1;
            end
          end
          S_WR: state_q <= S_GAP;
          S_GAP: begin
            if (gap_zero) begin
              if (step_q == LAST_STEP) begin
                state_q <= S_POLL_SETUP;
`ifdef QSFP_RSTSEQ_INSERT_GATE_EN
              end else if (step_q == LAST_STEP - 3'd1) begin
                state_q   <= S_RD_INS;
                addr_q    <= ADDR_STATUS_P0;
                ins_idx_q <= 2'd0;
                ins_ph_q  <= 1'b0;
`endif
              end else begin
                state_q <= S_WR;
                step_q  <= step_q + 3'd1;
                addr_q  <= ADDR_CONTROL;
                wdata_q <= {24'd0, STEP_WDATA[step_q + 3'd1]};
                wen_q   <= 1'b1;
              end
            end
          end
`ifdef QSFP_RSTSEQ_INSERT_GATE_EN
          // phase 0 samples the port shown on m_addr, phase 1 moves on
          S_RD_INS: begin
            if (!ins_ph_q) begin
              ins_q[ins_idx_q] <= m_rdata[8];
              ins_ph_q         <= 1'b1;
            end else if (ins_idx_q == 2'd3) begin
              state_q <= S_WR;
              step_q  <= LAST_STEP;
              addr_q  <= ADDR_CONTROL;
              wdata_q <= {24'd0, ins_q, 4'hF};
              wen_q   <= 1'b1;
            end else begin
              ins_idx_q <= ins_idx_q + 2'd1;
              addr_q    <= status_port_addr(ins_idx_q + 2'd1);
              ins_ph_q  <= 1'b0;
            end
          end
`endif
          S_POLL_SETUP: begin
            state_q <= S_POLL;
            addr_q  <= ADDR_STATUS_TOP;
          end
          // a match on the expiring cycle still counts as success
          S_POLL: begin
            if (ready) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              addr_q  <= ADDR_CONTROL;
            end else if (poll_zero) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end
          end
          S_ABORT_WR: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign seq_busy  = busy_q;
  assign seq_done  = done_q;
  assign seq_error = error_q;
  assign seq_step  = step_q;
  assign m_wen     = wen_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;

endmodule

// File: tb/tb_qsfp_i2c_rstseq.sv
// tb_qsfp_i2c_rstseq: directed bench for the QSFP I2C reset sequencer.
// Cycle n is the period starting at the n-th rising edge; a start held
// during cycle t0 yields the first CONTROL write in cycle t0+1.
module tb_qsfp_i2c_rstseq;
  localparam int unsigned STEP_DLY     = 4;
  localparam int unsigned POLL_TIMEOUT = 16;
`ifdef QSFP_RSTSEQ_INSERT_GATE_EN
  localparam int X = 8;   // extra cycles spent reading the four port status words
`else
  localparam int X = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        seq_busy, seq_done, seq_error, m_wen;
  logic [2:0]  seq_step;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic [7:0]  status_top = 8'h02;
  logic [3:0]  p_ins = 4'hF;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;

  int          wr_cyc[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cyc[$];

  qsfp_i2c_rstseq #(
    .STEP_DLY(STEP_DLY),
    .POLL_TIMEOUT(POLL_TIMEOUT),
    .TOP_READY_STATE(8'h02)
  ) dut (
    .sys_if_clk (clk),
    .sys_if_rstn(rstn),
    .start      (start),
    .abort      (abort),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .seq_error  (seq_error),
    .seq_step   (seq_step),
    .m_wen      (m_wen),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register block read model; junk in unrelated bits
  always_comb begin
    m_rdata = 32'h0;
    case (m_addr)
      32'h20: m_rdata = {24'hA5A5A0, status_top};
      32'h28: m_rdata = {23'h0, p_ins[0], 8'h5A};
      32'h2C: m_rdata = {23'h0, p_ins[1], 8'h5A};
      32'h30: m_rdata = {23'h0, p_ins[2], 8'h5A};
      32'h34: m_rdata = {23'h0, p_ins[3], 8'h5A};
      default: m_rdata = 32'h0;
    endcase
  end

  always @(negedge clk) begin
    if (m_wen) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(m_addr);
      wr_data.push_back(m_wdata);
    end
    if (seq_done) done_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_log();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    done_cyc.delete();
  endtask

  task automatic start_seq(output int t0);
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  // full successful sequence: five writes and one done pulse
  task automatic check_full(input string tag, input int t0, input logic [7:0] last_data);
    int          ecyc [5];
    logic [7:0]  edat [5];
    ecyc = '{1, 6, 11, 16, 21 + X};
    edat = '{8'h01, 8'h03, 8'h07, 8'h0F, last_data};
    wait_until(t0 + 40 + X);
    chk({tag, ".nwr"}, wr_cyc.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_cyc.size()) begin
        chk($sformatf("%s.wr%0d_cyc", tag, i), wr_cyc[i] - t0, ecyc[i]);
        chk($sformatf("%s.wr%0d_addr", tag, i), wr_addr[i], 32'h14);
        chk($sformatf("%s.wr%0d_data", tag, i), wr_data[i], {24'h0, edat[i]});
      end
    end
    chk({tag, ".ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk({tag, ".done_cyc"}, done_cyc[0] - t0, 28 + X);
    chk({tag, ".error"}, seq_error, 0);
    chk({tag, ".busy"}, seq_busy, 0);
  endtask

  initial begin
    int t0;
    tick();
    chk("rst.wen", m_wen, 0);
    chk("rst.addr", m_addr, 32'h14);
    chk("rst.wdata", m_wdata, 0);
    chk("rst.busy", seq_busy, 0);
    chk("rst.done", seq_done, 0);
    chk("rst.error", seq_error, 0);
    chk("rst.step", seq_step, 0);
    tick();
    rstn = 1'b1;
    tick();

    // 1: nominal sequence
    clear_log();
    start_seq(t0);
    chk("t1.busy_c1", seq_busy, 1);
    wait_until(t0 + 27 + X);
    chk("t1.busy_poll", seq_busy, 1);
    chk("t1.addr_poll", m_addr, 32'h20);
    tick();
    chk("t1.done_pulse", seq_done, 1);
    chk("t1.busy_end", seq_busy, 0);
    chk("t1.step_end", seq_step, 4);
    chk("t1.addr_end", m_addr, 32'h14);
    tick();
    chk("t1.done_once", seq_done, 0);
    check_full("t1", t0, 8'hFF);

    // 2: STATUS_TOP never ready -> timeout after 16 poll cycles
    clear_log();
    status_top = 8'h01;
    start_seq(t0);
    wait_until(t0 + 42 + X);
    chk("t2.err_before", seq_error, 0);
    chk("t2.busy_before", seq_busy, 1);
    tick();
    chk("t2.err_set", seq_error, 1);
    chk("t2.busy_end", seq_busy, 0);
    wait_until(t0 + 50 + X);
    chk("t2.ndone", done_cyc.size(), 0);
    chk("t2.err_sticky", seq_error, 1);

    // 2b: next start clears error; ready arrives on the expiring poll cycle
    clear_log();
    start_seq(t0);
    chk("t2b.err_clr", seq_error, 0);
    wait_until(t0 + 42 + X);
    status_top = 8'h02;
    tick();
    chk("t2b.done_at_expiry", seq_done, 1);
    chk("t2b.err", seq_error, 0);

    // 3: abort in the gap after step 1
    wait_until(cyc + 5);
    clear_log();
    start_seq(t0);
    wait_until(t0 + 8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3.wen", m_wen, 1);
    chk("t3.addr", m_addr, 32'h14);
    chk("t3.wdata", m_wdata, 0);
    tick();
    chk("t3.busy", seq_busy, 0);
    chk("t3.wen_off", m_wen, 0);
    wait_until(t0 + 40);
    chk("t3.nwr", wr_cyc.size(), 3);
    if (wr_cyc.size() >= 3) begin
      chk("t3.abort_cyc", wr_cyc[2] - t0, 9);
      chk("t3.abort_data", wr_data[2], 0);
    end
    chk("t3.ndone", done_cyc.size(), 0);

    // 4: async reset during step 2, then a full replay
    clear_log();
    start_seq(t0);
    wait_until(t0 + 13);
    rstn = 1'b0;
    #1;
    chk("t4.wen", m_wen, 0);
    chk("t4.addr", m_addr, 32'h14);
    chk("t4.wdata", m_wdata, 0);
    chk("t4.step", seq_step, 0);
    chk("t4.busy", seq_busy, 0);
    tick();
    rstn = 1'b1;
    wait_until(t0 + 45);
    chk("t4.nwr", wr_cyc.size(), 3);
    clear_log();
    start_seq(t0);
    check_full("t4r", t0, 8'hFF);

    // 5: starts while busy ignored; start+abort in IDLE starts a sequence
    clear_log();
    start_seq(t0);
    wait_until(t0 + 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(t0 + 27 + X);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_full("t5", t0, 8'hFF);
    clear_log();
    start = 1'b1;
    abort = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t5b.busy", seq_busy, 1);
    check_full("t5b", t0, 8'hFF);

`ifdef QSFP_RSTSEQ_INSERT_GATE_EN
    // 6: only ports 1 and 3 inserted
    clear_log();
    p_ins = 4'b1010;
    start_seq(t0);
    check_full("t6", t0, 8'hAF);
    p_ins = 4'hF;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qsfp_i2c_rstseq.md
Name: qsfp_i2c_rstseq

Overview:
- Bus master on the QSFP I2C register interface (sys_if write-enable/address/wdata/rdata, same map as the QSFP I2C register block).
- On a start pulse, releases the CONTROL reset bits in the fixed order TOP, I2C, MUX0, MUX1, QSFP_0..3, waiting a programmable gap after each write.
- Then polls STATUS_TOP until the top FSM reports ready, or times out.
- Replaces ad hoc software bring-up with a deterministic hardware sequence.

Parameters:
- STEP_DLY, 1000: idle cycles after each CONTROL write before the next step (min 1).
- POLL_TIMEOUT, 100000: max poll cycles waiting for the ready state (min 1).
- TOP_READY_STATE, 8'h02: STATUS_TOP[7:0] value meaning the top FSM is ready.

Ports:
- sys_if_clk  in  1  clock
- sys_if_rstn  in  1  reset
- start  in  1  single-cycle pulse; begins the sequence when idle
- abort  in  1  single-cycle pulse; cancels the sequence and re-asserts all resets
- seq_busy  out  1  high from the cycle after an accepted start until DONE, ERROR or IDLE is reached
- seq_done  out  1  single-cycle pulse on success
- seq_error  out  1  sticky timeout flag; cleared by the next accepted start
- seq_step  out  3  index of the current or last write step, 0..4
- m_wen  out  1  register write strobe
- m_addr  out  32  register address
- m_wdata  out  32  register write data
- m_rdata  in  32  register read data, combinational from m_addr

Behaviour:
- Interface decision: single clock sys_if_clk; reset sys_if_rstn is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; m_addr = 0x14.
- Write steps, all to CONTROL at 0x14, with m_wdata cumulative:
  - step 0 = 0x01
  - step 1 = 0x03
  - step 2 = 0x07
  - step 3 = 0x0F
  - step 4 = 0xFF (all four QSFP bits together)
- Bus rules:
  - m_wen high for exactly one cycle per write; m_addr/m_wdata are valid in that cycle.
  - m_wen is 0 in every other cycle; m_wdata holds its last value.
  - Reads: m_addr is registered; m_rdata is sampled at the clock edge ending the first cycle m_addr shows the new value.
- FSM states:
  - IDLE: on start, seq_error<=0 and go to WR with step=0. abort is ignored here.
  - WR: assert m_wen, load the delay counter with STEP_DLY, go to GAP.
  - GAP: decrement the counter; at 0, go to WR with step+1 if step<4, else go to POLL_SETUP.
  - POLL_SETUP: m_addr<=0x20, load the timeout counter with POLL_TIMEOUT, go to POLL.
  - POLL: each cycle compare m_rdata[7:0] with TOP_READY_STATE.
    - Match: pulse seq_done, m_addr<=0x14, go to IDLE.
    - Counter reaches 0 with no match: seq_error<=1, go to IDLE.
    - A match in the same cycle the counter expires counts as success.
  - ABORT_WR: from any non-IDLE state on abort: m_addr<=0x14, m_wdata<=0, m_wen=1 for one cycle, then IDLE. No seq_done.
- Timing: start in cycle 0 gives the step-0 write in cycle 1. Writes are spaced STEP_DLY+1 cycles apart.
- Simultaneous start and abort in IDLE: start wins, abort is ignored.
- start while busy: ignored, with no queueing.
- Async reset mid-sequence: immediate return to reset values, with no bus write issued. The register block resets CONTROL to 0 on the same reset.
- Counter widths: $clog2(param+1). Counters saturate at 0.

Optional Feature:
- Macro: QSFP_RSTSEQ_INSERT_GATE_EN.
- Defined: before step 4, insert a state RD_INS that reads STATUS_P0..P3 (0x28, 0x2c, 0x30, 0x34), one read per two cycles, and captures bit 8 of each.
  - Step-4 wdata becomes {ins3,ins2,ins1,ins0,4'hF}: only inserted ports leave reset.
  - abort during RD_INS behaves as in any other state.
- Undefined: step-4 wdata is 0xFF and RD_INS does not exist.

Decomposition:
- Package qsfp_i2c_pkg holds:
  - the register address constants (CONTROL 0x14, STATUS_TOP 0x20, STATUS_P0..P3 0x28..0x34);
  - the step wdata constant array;
  - the FSM state enum;
  - CONTROL bit positions.
- One sub-module, qsfp_rstseq_timer: loadable down-counter with load/enable inputs and a zero flag. Instantiated twice, once for the step gap and once for the poll timeout.

Test Plan (STEP_DLY=4, POLL_TIMEOUT=16, TOP_READY_STATE=8'h02, macro undefined unless stated):
1. start at cycle 0; model returns 0x02 at 0x20 -> writes 0x01/0x03/0x07/0x0F/0xFF at cycles 1, 6, 11, 16, 21; seq_done pulses; seq_busy falls; seq_error=0.
2. STATUS_TOP held at 0x01 -> after 16 poll cycles seq_error=1, no seq_done; the next start clears seq_error.
3. abort in cycle 8 (GAP after step 1) -> one write of 0x00 to 0x14 in cycle 9; no further writes; IDLE, seq_busy=0.
4. sys_if_rstn low for 1 cycle during step 2 -> all outputs 0 immediately, no m_wen; a fresh start replays the full sequence from step 0.
5. start pulses during GAP and POLL, and start+abort together in IDLE -> busy-time starts ignored; the simultaneous pair starts a sequence.
6. Macro defined; STATUS_P1 and P3 have bit 8 set, P0 and P2 clear -> step-4 write of 0xAF to 0x14.
